// File: rtl/param_reg_file_pkg.sv
// Package: param_reg_file_pkg
// Purpose : Shared constants for the CPU register bank and its scoreboard.
//           Decode and writeback both import this package, so they agree on
//           the default datapath width and the number of write ports.
// Contents:
//   DEF_DATA_W - default register width for the CPU datapath
//   DEF_ADDR_W - default address width (2**DEF_ADDR_W registers)
//   NUM_WR     - number of write ports; port 1 has priority over port 0
package param_reg_file_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int NUM_WR     = 2;

endpackage : param_reg_file_pkg

// File: rtl/rf_scoreboard.sv
// Module : rf_scoreboard
// Purpose: Per-register busy scoreboard. Decode reserves a destination
//          register, and writeback releases it. Each bit is updated on every
//          edge with the priority rst > reserve > release.
// Ports  :
//   clk      in  clock
//   rst      in  synchronous active-high reset, clears every busy bit
//   wr_en    in  [NUM_WR]        write enables, each one releases its address
//   wr_addr  in  [NUM_WR*ADDR_W] packed write addresses
//   rsv_en   in  reserve strobe
//   rsv_addr in  [ADDR_W]        register to reserve
//   busy     out [2**ADDR_W]     registered busy vector
module rf_scoreboard
  import param_reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [(2**ADDR_W)-1:0]   busy
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0] busy_nxt;

  // Release first, then reserve. A new producer that issues in the same
  // cycle as the old producer's writeback keeps the register busy.
  always_comb begin
    // NOTE: assign a default before any conditional update, so every path
    // drives busy_nxt and no latch is inferred.
    busy_nxt = busy;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en[k]) begin
        busy_nxt[wr_addr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (rsv_en) begin
      busy_nxt[rsv_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every flop
    // samples pre-edge values regardless of the order of the blocks.
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

endmodule : rf_scoreboard

// File: rtl/param_reg_file.sv
// Module : param_reg_file
// Purpose: Parametrised multi-port register bank for the CPU datapath.
//          It has NUM_RD combinational read ports and two write ports, with
//          write port 1 taking priority. Options are a hardwired zero
//          register and forwarding of same-cycle write data to the reads.
//          A busy scoreboard is included for decode and writeback.
// Ports  :
//   clk      in  clock, all state updates on the rising edge
//   rst      in  synchronous active-high reset (registers and busy -> 0)
//   rd_addr  in  [NUM_RD*ADDR_W] packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  out [NUM_RD*DATA_W] packed read data,      port i at [i*DATA_W +: DATA_W]
//   wr_en    in  [2]             write enable per write port
//   wr_addr  in  [2*ADDR_W]      packed write addresses
//   wr_data  in  [2*DATA_W]      packed write data
//   rsv_en   in  reserve rsv_addr as the destination of an issued instruction
//   rsv_addr in  [ADDR_W]        register to reserve
//   busy     out [2**ADDR_W]     registered busy scoreboard
module param_reg_file
  import param_reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [(2**ADDR_W)-1:0]   busy
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NUM_WR-1:0] wr_go;

  // A write to the hardwired zero register is dropped before it reaches
  // storage.
  always_comb begin
    wr_go = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      wr_go[k] = wr_en[k] && !(ZERO_REG && (wr_addr[k*ADDR_W +: ADDR_W] == '0));
    end
  end

  // Ports are visited in ascending order. If both ports target one address,
  // the later non-blocking update (port 1) is the one that takes effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the bank is cleared on reset because software relies on all
      // registers reading zero after reset. This uses flops, not a RAM macro.
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_go[k]) begin
          regs[wr_addr[k*ADDR_W +: ADDR_W]] <= wr_data[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;

    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    // Start from the stored value, then override with forwarded write data.
    // Port 1 is checked last, so it wins when both ports match. The zero
    // register check comes last, so it also masks the forwarded data.
    always_comb begin
      rv = regs[ra];
      if (BYPASS) begin
        for (int k = 0; k < NUM_WR; k++) begin
          if (wr_en[k] && (wr_addr[k*ADDR_W +: ADDR_W] == ra)) begin
            rv = wr_data[k*DATA_W +: DATA_W];
          end
        end
      end
      if (ZERO_REG && (ra == '0)) begin
        rv = '0;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = rv;
  end : g_rd

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy)
  );

endmodule : param_reg_file
